noc_router_input_vc: RTL and testbench
======================================

// Module: noc_router_input_vc
// PURPOSE
//  Generalised router input port: one physical link carries VCHANNELS virtual channels. Each VC has
//  its own DEPTH-entry flit FIFO, a route-lookup stage and a one-entry output register.
//  Each VC is independently unicast or multicast, as selected by MCAST_VC.
//  Sits between the link receiver and the per-output switch arbiters of a mesh router.
// PARAMETERS
//  FLIT_WIDTH  32          flit width, bits
//  VCHANNELS   2           number of virtual channels (>=1)
//  DEPTH       4           FIFO entries per VC (>=2, any value)
//  DESTS       4           number of destinations
//  OUTPUTS     5           number of router output ports
//  ROUTES      '0          [DESTS*OUTPUTS-1:0]; ROUTES[d*OUTPUTS+:OUTPUTS] = output mask for dest d
//  MCAST_VC    'b01        [VCHANNELS-1:0]; bit v=1 -> VC v is a multicast channel
//  DEST_MSB    FLIT_WIDTH-1  top bit of the header destination field
// PORTS
//  clk         in   1                      clock; all state on rising edge
//  rst         in   1                      asynchronous reset, active high
//  in_flit     in   FLIT_WIDTH             flit shared by all VCs
//  in_last     in   1                      last flit of packet
//  in_valid    in   VCHANNELS              per-VC valid, at most one bit set
//  in_ready    out  VCHANNELS              per-VC ready (FIFO not full)
//  out_flit    out  VCHANNELS*FLIT_WIDTH   per-VC output flit
//  out_last    out  VCHANNELS              per-VC output last
//  out_valid   out  VCHANNELS*OUTPUTS      per-VC output request mask
//  out_ready   in   VCHANNELS*OUTPUTS      per-VC per-output grant/ready
//  err_vc      out  1                      sticky: in_valid multi-hot seen
//  err_noroute out  VCHANNELS              sticky per VC: header resolved to an empty mask
// BEHAVIOUR
//  Reset (async, rst=1): FIFOs empty, VC state HEAD, output registers invalid.
//   in_ready=all 1, out_valid=0, out_last=0, out_flit=0, err_*=0. Reset mid-packet discards all flits.
//  Input: push VC v when in_valid[v]&in_ready[v]. in_ready[v]=(count_v!=DEPTH), derived from registers.
//   Push+pop in the same cycle leaves count unchanged. A full FIFO never accepts, even if it pops that cycle.
//   in_valid with >1 bit set: no VC pushes that cycle; err_vc set.
//  Route FSM per VC, HEAD/BODY:
//   HEAD + head flit popped: compute mask, hold it in route_q, go to BODY unless last.
//   BODY: each popped flit reuses route_q; the last flit returns the FSM to HEAD. Single-flit packets stay in HEAD.
//  Mask, unicast VC: d = flit[DEST_MSB -: $clog2(DESTS)]; mask = ROUTES[d]. d>=DESTS gives mask 0.
//  Mask, multicast VC: m = flit[DEST_MSB -: DESTS]; mask = OR of ROUTES[d] over every set bit of m.
//  Mask==0: the whole packet is popped and dropped at 1 flit/cycle, nothing is presented at the output,
//   and err_noroute[v] is set.
//  Output register per VC:
//   - Loads the FIFO head when empty, or when its current entry retires in this cycle.
//   - Minimum latency: push at cycle t, out_valid at t+2.
//   - Sustains 1 flit/cycle/VC when out_ready is held.
//   - out_valid[v] = pend_v, the pending output mask. Loaded with the route mask.
//  Unicast retire: any bit of (pend_v & out_ready[v]).
//  Multicast: each cycle pend_v <= pend_v & ~out_ready[v]. The entry retires in the cycle that
//   (pend_v & ~out_ready[v]) == 0. A partially granted flit keeps out_flit/out_last stable.
//  out_valid bits never rise after load; they only clear. out_flit is stable while any out_valid bit is set.
//  VCs are fully independent: a blocked VC never stalls another VC.
// TESTING
//  T1 unicast VC1: 3-flit packet to d=2, ROUTES[2]=5'b00100, out_ready=all 1 ->
//     out_valid[1]=00100 for 3 consecutive cycles starting 2 cycles after the first push; out_last on the 3rd flit.
//  T2 multicast VC0: head m=4'b0011, ROUTES[0]=00001, ROUTES[1]=00100; out_ready[0] pulses 00001 then 00100 ->
//     out_valid 00101 -> 00100 -> 0; next flit presented the cycle after.
//  T3 backpressure: out_ready[1]=0, push 5 flits on VC1, DEPTH=4 ->
//     in_ready[1] drops after 4 FIFO + 1 register; VC0 traffic still flows.
//  T4 no route: unicast head with ROUTES[d]=0, 2-flit packet -> out_valid stays 0, both flits drained,
//     err_noroute[v]=1; the next packet routes normally.
//  T5 in_valid=2'b11 -> no push on either VC, err_vc=1.
//  T6 assert rst mid-packet with a full FIFO -> in_ready all 1, out_valid 0 in the same cycle;
//     a fresh head after release routes correctly.

Source files
------------

// File: rtl/noc_router_input_vc.sv
// ============================================================================
// Module      : noc_router_input_vc
// Description : Router input port with per-VC flit FIFO, route lookup and
//               one-entry output register; each VC unicast or multicast.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module noc_router_input_vc #(
    parameter int                         FLIT_WIDTH = 32,
    parameter int                         VCHANNELS  = 2,
    parameter int                         DEPTH      = 4,
    parameter int                         DESTS      = 4,
    parameter int                         OUTPUTS    = 5,
    parameter logic [DESTS*OUTPUTS-1:0]   ROUTES     = '0,
    parameter logic [VCHANNELS-1:0]       MCAST_VC   = VCHANNELS'(1),
    parameter int                         DEST_MSB   = FLIT_WIDTH - 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [FLIT_WIDTH-1:0]           in_flit,
    input  logic                            in_last,
    input  logic [VCHANNELS-1:0]            in_valid,
    output logic [VCHANNELS-1:0]            in_ready,
    output logic [VCHANNELS*FLIT_WIDTH-1:0] out_flit,
    output logic [VCHANNELS-1:0]            out_last,
    output logic [VCHANNELS*OUTPUTS-1:0]    out_valid,
    input  logic [VCHANNELS*OUTPUTS-1:0]    out_ready,
    output logic                            err_vc,
    output logic [VCHANNELS-1:0]            err_noroute
);

    localparam int c_ptr_w  = $clog2(DEPTH);
    localparam int c_cnt_w  = $clog2(DEPTH + 1);
    localparam int c_dest_w = (DESTS > 1) ? $clog2(DESTS) : 1;

    localparam logic [0:0] c_st_head = 1'b0;
    localparam logic [0:0] c_st_body = 1'b1;

    logic w_push_ok;
    logic r_err_vc;

    // A multi-hot in_valid is ambiguous, so the whole beat is refused.
    assign w_push_ok = $onehot0(in_valid);
    assign err_vc    = r_err_vc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)             r_err_vc <= 1'b0;
        else if (!w_push_ok) r_err_vc <= 1'b1;
    end

    for (genvar v = 0; v < VCHANNELS; v++) begin : g_vc
        logic [c_cnt_w-1:0]    r_count;
        logic [c_ptr_w-1:0]    r_wr_ptr;
        logic [c_ptr_w-1:0]    r_rd_ptr;
        logic [FLIT_WIDTH:0]   r_mem [DEPTH];
        logic [0:0]            r_state;
        logic [0:0]            w_state_nxt;
        logic [OUTPUTS-1:0]    r_route;
        logic [OUTPUTS-1:0]    r_pend;
        logic [FLIT_WIDTH-1:0] r_flit;
        logic                  r_last;
        logic                  r_noroute;
        logic [FLIT_WIDTH-1:0] w_head_flit;
        logic                  w_head_last;
        logic [OUTPUTS-1:0]    w_ready;
        logic [OUTPUTS-1:0]    w_head_mask;
        logic [OUTPUTS-1:0]    w_mask;
        logic [OUTPUTS-1:0]    w_pend_hold;
        logic                  w_push;
        logic                  w_pop;
        logic                  w_load;
        logic                  w_retire;
        logic                  w_slot_free;

        assign in_ready[v]                = (r_count != c_cnt_w'(DEPTH));
        assign w_push                     = in_valid[v] & in_ready[v] & w_push_ok;
        assign {w_head_last, w_head_flit} = r_mem[r_rd_ptr];
        assign w_ready                    = out_ready[v*OUTPUTS +: OUTPUTS];

        if (MCAST_VC[v]) begin : g_mcast
            always_comb begin
                w_head_mask = '0;
                for (int d = 0; d < DESTS; d++) begin
                    if (w_head_flit[DEST_MSB - DESTS + 1 + d])
                        w_head_mask = w_head_mask | ROUTES[d*OUTPUTS +: OUTPUTS];
                end
            end
            // Grants accumulate across cycles; retire once nothing is left outstanding.
            assign w_pend_hold = r_pend & ~w_ready;
            assign w_retire    = (r_pend != '0) && (w_pend_hold == '0);
        end else begin : g_ucast
            logic [c_dest_w-1:0] w_dest;
            assign w_dest = w_head_flit[DEST_MSB -: c_dest_w];
            always_comb begin
                w_head_mask = '0;
                for (int d = 0; d < DESTS; d++) begin
                    if (w_dest == c_dest_w'(d))
                        w_head_mask = ROUTES[d*OUTPUTS +: OUTPUTS];
                end
            end
            assign w_pend_hold = r_pend;
            assign w_retire    = |(r_pend & w_ready);
        end

        // Route FSM: state register.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state <= c_st_head;
                r_route <= '0;
            end else begin
                r_state <= w_state_nxt;
                if (w_pop && (r_state == c_st_head))
                    r_route <= w_head_mask;
            end
        end

        // Route FSM: next state.
        always_comb begin
            w_state_nxt = r_state;
            case (r_state)
                c_st_head: if (w_pop && !w_head_last) w_state_nxt = c_st_body;
                c_st_body: if (w_pop &&  w_head_last) w_state_nxt = c_st_head;
                default:   w_state_nxt = c_st_head;
            endcase
        end

        // Route FSM: outputs. Unroutable flits are popped without waiting for the slot.
        always_comb begin
            w_mask      = (r_state == c_st_head) ? w_head_mask : r_route;
            w_slot_free = (r_pend == '0) || w_retire;
            w_pop       = (r_count != '0) && ((w_mask == '0) || w_slot_free);
            w_load      = w_pop && (w_mask != '0);
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_count  <= '0;
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push)
                    r_wr_ptr <= (r_wr_ptr == c_ptr_w'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
                if (w_pop)
                    r_rd_ptr <= (r_rd_ptr == c_ptr_w'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (w_push)
                r_mem[r_wr_ptr] <= {in_last, in_flit};
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_pend    <= '0;
                r_flit    <= '0;
                r_last    <= 1'b0;
                r_noroute <= 1'b0;
            end else begin
                if (w_load) begin
                    r_pend <= w_mask;
                    r_flit <= w_head_flit;
                    r_last <= w_head_last;
                end else if (w_retire) begin
                    r_pend <= '0;
                end else begin
                    r_pend <= w_pend_hold;
                end
                if (w_pop && (r_state == c_st_head) && (w_head_mask == '0))
                    r_noroute <= 1'b1;
            end
        end

        assign out_valid[v*OUTPUTS +: OUTPUTS]       = r_pend;
        assign out_flit[v*FLIT_WIDTH +: FLIT_WIDTH]  = r_flit;
        assign out_last[v]                           = r_last;
        assign err_noroute[v]                        = r_noroute;
    end

endmodule

`default_nettype wire

// File: tb/tb_noc_router_input_vc.sv
// ============================================================================
// Module      : tb_noc_router_input_vc
// Description : Scoreboard bench for noc_router_input_vc (VC0 multicast,
//               VC1 unicast) with directed timing and error-flag checks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_noc_router_input_vc;

    localparam logic [19:0] c_routes = {5'b00000, 5'b00100, 5'b00100, 5'b00001};

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_flit;
    logic        in_last;
    logic [1:0]  in_valid;
    logic [1:0]  in_ready;
    logic [63:0] out_flit;
    logic [1:0]  out_last;
    logic [9:0]  out_valid;
    logic [9:0]  out_ready;
    logic        err_vc;
    logic [1:0]  err_noroute;

    noc_router_input_vc #(
        .FLIT_WIDTH(32), .VCHANNELS(2), .DEPTH(4), .DESTS(4), .OUTPUTS(5),
        .ROUTES(c_routes), .MCAST_VC(2'b01), .DEST_MSB(31)
    ) dut (
        .clk(clk), .rst(rst), .in_flit(in_flit), .in_last(in_last),
        .in_valid(in_valid), .in_ready(in_ready), .out_flit(out_flit),
        .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
        .err_vc(err_vc), .err_noroute(err_noroute)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] flit;
        logic        last;
        logic [4:0]  mask;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [4:0]  m_pend [2];
    logic [31:0] m_flit [2];
    logic        m_last [2];
    int          checks   = 0;
    int          failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: new output entries are matched against the scoreboard, held entries must stay stable.
    task automatic mon_vc(input int v);
        logic [4:0]  ov;
        logic [4:0]  rdy;
        logic [31:0] of;
        logic        ol;
        exp_t        e;
        ov  = out_valid[v*5 +: 5];
        rdy = out_ready[v*5 +: 5];
        of  = out_flit[v*32 +: 32];
        ol  = out_last[v];
        if (m_pend[v] == 5'b0) begin
            if (ov != 5'b0) begin
                if ((v == 0 && q0.size() == 0) || (v == 1 && q1.size() == 0)) begin
                    chk($sformatf("vc%0d_unexpected_out", v), 64'(ov), 64'd0);
                end else begin
                    if (v == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    chk($sformatf("vc%0d_entry", v), 64'({of, ol, ov}), 64'({e.flit, e.last, e.mask}));
                    m_pend[v] = e.mask;
                    m_flit[v] = e.flit;
                    m_last[v] = e.last;
                end
            end
        end else begin
            chk($sformatf("vc%0d_hold", v), 64'({of, ol, ov}), 64'({m_flit[v], m_last[v], m_pend[v]}));
        end
        if (m_pend[v] != 5'b0) begin
            if (v == 0)                  m_pend[v] = m_pend[v] & ~rdy;
            else if (|(m_pend[v] & rdy)) m_pend[v] = 5'b0;
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon_vc(0);
            mon_vc(1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int v, input logic [31:0] f, input logic l, input logic [4:0] m);
        exp_t e;
        in_valid    = 2'b00;
        in_valid[v] = 1'b1;
        in_flit     = f;
        in_last     = l;
        e.flit = f;
        e.last = l;
        e.mask = m;
        if (m != 5'b0) begin
            if (v == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    task automatic idle();
        in_valid = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        in_flit   = '0;
        in_last   = 1'b0;
        in_valid  = 2'b00;
        out_ready = '1;
        m_pend    = '{5'b0, 5'b0};
        m_flit    = '{32'b0, 32'b0};
        m_last    = '{1'b0, 1'b0};
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'h3);
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_out_last", 64'(out_last), 64'h0);
        chk("rst_out_flit", out_flit, 64'h0);
        chk("rst_err", 64'({err_vc, err_noroute}), 64'h0);
        rst = 1'b0;
        tick();

        // T1: unicast 3-flit packet to dest 2
        drive(1, {2'b10, 30'h1}, 1'b0, 5'b00100); tick();
        chk("t1_not_yet", 64'(out_valid[9:5]), 64'h0);
        drive(1, 32'h0000_0002, 1'b0, 5'b00100); tick();
        chk("t1_first", 64'(out_valid[9:5]), 64'h04);
        drive(1, 32'h0000_0003, 1'b1, 5'b00100); tick();
        idle();
        chk("t1_second", 64'({out_last[1], out_valid[9:5]}), 64'h04);
        tick();
        chk("t1_third", 64'({out_last[1], out_valid[9:5]}), 64'h24);
        tick();
        chk("t1_done", 64'(out_valid[9:5]), 64'h0);

        // T2: multicast head m=0011 with partial grants
        out_ready[4:0] = 5'b00000;
        drive(0, {4'b0011, 28'h00A}, 1'b0, 5'b00101); tick();
        drive(0, 32'h0000_00B0, 1'b1, 5'b00101); tick();
        idle();
        chk("t2_load", 64'(out_valid[4:0]), 64'h05);
        out_ready[4:0] = 5'b00001; tick();
        chk("t2_partial", 64'(out_valid[4:0]), 64'h04);
        out_ready[4:0] = 5'b00100; tick();
        chk("t2_next_flit", 64'({out_last[0], out_valid[4:0]}), 64'h25);
        out_ready[4:0] = 5'b00000; tick();
        chk("t2_blocked", 64'(out_valid[4:0]), 64'h05);
        out_ready[4:0] = 5'b00101; tick();
        chk("t2_drained", 64'(out_valid[4:0]), 64'h0);
        out_ready = '1;

        // T3: backpressure on VC1, VC0 keeps flowing
        out_ready[9:5] = 5'b00000;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) chk("t3_ready_before_full", 64'(in_ready[1]), 64'h1);
            drive(1, {2'b10, 30'(16 + i)}, (i == 4), 5'b00100);
            tick();
        end
        idle();
        chk("t3_full", 64'(in_ready[1]), 64'h0);
        drive(0, {4'b0001, 28'h005}, 1'b1, 5'b00001); tick();
        idle(); tick();
        chk("t3_vc0_flows", 64'(out_valid[4:0]), 64'h01);
        chk("t3_vc1_still_blocked", 64'({in_ready[1], out_valid[9:5]}), 64'h04);
        out_ready[9:5] = 5'b11111;
        repeat (8) tick();
        chk("t3_vc1_drained", 64'({in_ready[1], out_valid[9:5]}), 64'h20);

        // T4: unroutable 2-flit packet, then a routable one
        drive(1, {2'b11, 30'h7}, 1'b0, 5'b00000); tick();
        drive(1, 32'h0000_0008, 1'b1, 5'b00000); tick();
        idle();
        chk("t4_hidden", 64'(out_valid[9:5]), 64'h0);
        tick();
        chk("t4_err_noroute", 64'(err_noroute), 64'h2);
        chk("t4_hidden2", 64'(out_valid[9:5]), 64'h0);
        tick();
        drive(1, {2'b10, 30'h9}, 1'b1, 5'b00100); tick();
        idle(); tick();
        chk("t4_next_routes", 64'(out_valid[9:5]), 64'h04);
        tick();

        // T5: multi-hot in_valid
        in_valid = 2'b11;
        in_flit  = {2'b10, 30'h55};
        in_last  = 1'b1;
        tick();
        idle();
        chk("t5_err_vc", 64'(err_vc), 64'h1);
        chk("t5_no_push", 64'(in_ready), 64'h3);
        repeat (3) tick();
        chk("t5_no_output", 64'(out_valid), 64'h0);

        // T6: reset mid-packet with a full FIFO
        out_ready[9:5] = 5'b00000;
        for (int i = 0; i < 5; i++) begin
            drive(1, {2'b10, 30'(32 + i)}, 1'b0, 5'b00100);
            tick();
        end
        idle();
        chk("t6_full", 64'(in_ready[1]), 64'h0);
        rst = 1'b1;
        #1;
        chk("t6_rst_in_ready", 64'(in_ready), 64'h3);
        chk("t6_rst_out_valid", 64'(out_valid), 64'h0);
        chk("t6_rst_err", 64'({err_vc, err_noroute, out_last}), 64'h0);
        q0.delete();
        q1.delete();
        m_pend = '{5'b0, 5'b0};
        out_ready = '1;
        tick();
        rst = 1'b0;
        tick();
        drive(1, {2'b01, 30'hC}, 1'b1, 5'b00100); tick();
        idle();
        chk("t6_after_lat", 64'(out_valid[9:5]), 64'h0);
        tick();
        chk("t6_fresh_head", 64'({out_last[1], out_valid[9:5]}), 64'h24);

        repeat (10) tick();
        chk("sb_empty", 64'(q0.size() + q1.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
